instr_encoder: RTL and testbench

Program-loader block for the RV32I single-cycle core: accepts decoded instruction descriptions (kind, register indices, immediate) over a valid/ready stream, assembles the 32-bit machine word for the four instruction classes the core's control decoder supports (lw, sw, R-type, beq), and writes the words sequentially into instruction memory from word address 0. It is the encoding counterpart of the core's control decoder. It is used by the boot path and by benches to fill imem before the core is released from reset.

---
 rtl/instr_encoder.sv | 164 ++++++++++++++++
 tb/tb_instr_encoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
//==============================================================================
// instr_encoder: assembles RV32I lw/sw/R-type/beq words from descriptors and
// writes them sequentially into imem from address 0.
// Optional immediate range checking: define ENC_RANGE_CHECK_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module instr_encoder #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_kind,
    input  logic [2:0]    in_funct3,
    input  logic          in_funct7_5,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [12:0]   in_imm,
    input  logic          in_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [AW:0]   count,
    output logic          done,
    output logic          err_imm
);

    localparam int           DEPTH      = 1 << AW;
    localparam logic [AW:0]  c_LAST_CNT = (AW+1)'(DEPTH - 1);
    localparam logic [31:0]  c_NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          ready_q, ready_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic [31:0]   w_word;
    logic [31:0]   w_wdata;
    logic          w_reject;

    always_comb begin
        w_word = 32'h0;
        case (in_kind)
            2'b00: w_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            2'b01: w_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            2'b10: w_word = {1'b0, in_funct7_5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            default: w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                               in_imm[4:1], in_imm[11], 7'b1100011};
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // A 12-bit signed value fits iff bits 12 and 11 agree; beq also needs an even offset.
    always_comb begin
        w_reject = 1'b0;
        case (in_kind)
            2'b00, 2'b01: w_reject = (in_imm[12] != in_imm[11]);
            2'b11:        w_reject = in_imm[0];
            default:      w_reject = 1'b0;
        endcase
    end
`else
    logic w_unused;
    assign w_reject = 1'b0;
    assign w_unused = in_imm[0];
`endif

    assign w_wdata = w_reject ? c_NOP : w_word;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        done_d  = done_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    count_d = '0;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                // A restart discards any beat presented in the same cycle.
                if (start) begin
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (in_valid && ready_q) begin
                    we_d    = 1'b1;
                    addr_d  = count_q[AW-1:0];
                    wdata_d = w_wdata;
                    count_d = count_q + (AW+1)'(1);
                    err_d   = err_q | w_reject;
                    if (in_last || (count_q == c_LAST_CNT)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_d = 1'b1;
                if (start) begin
                    state_d = RUN;
                    count_d = '0;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            count_q <= count_d;
            err_q   <= err_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready   = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign done       = done_q;
    assign err_imm    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
//==============================================================================
// tb_instr_encoder: directed scoreboard bench for instr_encoder (AW=2 build).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_instr_encoder;

    localparam int AW = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_kind;
    logic [2:0]    in_funct3;
    logic          in_funct7_5;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [12:0]   in_imm;
    logic          in_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          done;
    logic          err_imm;

    instr_encoder #(.AW(AW)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_kind     (in_kind),
        .in_funct3   (in_funct3),
        .in_funct7_5 (in_funct7_5),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .in_last     (in_last),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .count       (count),
        .done        (done),
        .err_imm     (err_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [AW:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got addr %0d data 0x%08h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_addr", 32'(imem_addr), 32'(e.addr));
                chk("strobe_data", imem_wdata, e.data);
                chk("strobe_count", 32'(count), 32'(e.cnt));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] k, input logic [2:0] f3, input logic f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [12:0] imm, input logic last);
        in_valid    = 1'b1;
        in_kind     = k;
        in_funct3   = f3;
        in_funct7_5 = f7;
        in_rd       = rd;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_imm      = imm;
        in_last     = last;
    endtask

    task automatic expect_w(input logic [AW-1:0] a, input logic [31:0] d, input logic [AW:0] c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cnt  = c;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_kind     = 2'b00;
        in_funct3   = 3'b000;
        in_funct7_5 = 1'b0;
        in_rd       = 5'd0;
        in_rs1      = 5'd0;
        in_rs2      = 5'd0;
        in_imm      = 13'd0;
        in_last     = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_imm), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", 32'(in_ready), 32'd0);

        // lw x5,8(x2)
        pulse_start();
        chk("run_ready", 32'(in_ready), 32'd1);
        drive(2'b00, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8, 1'b0);
        expect_w(2'd0, 32'h0081_2283, 3'd1);
        step();
        in_valid = 1'b0;
        chk("lw_we", 32'(imem_we), 32'd1);
        step();

        // Back-to-back sw / sub / beq(last)
        pulse_start();
        chk("restart_count", 32'(count), 32'd0);
        drive(2'b01, 3'd0, 1'b0, 5'd0, 5'd3, 5'd6, 13'd12, 1'b0);
        expect_w(2'd0, 32'h0061_A623, 3'd1);
        step();
        drive(2'b10, 3'd0, 1'b1, 5'd7, 5'd5, 5'd6, 13'd0, 1'b0);
        expect_w(2'd1, 32'h4062_83B3, 3'd2);
        step();
        drive(2'b11, 3'd0, 1'b0, 5'd0, 5'd5, 5'd6, 13'h1FFC, 1'b1);
        expect_w(2'd2, 32'hFE62_8EE3, 3'd3);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("b2b_ready_after_last", 32'(in_ready), 32'd0);
        chk("b2b_done_during_strobe", 32'(done), 32'd0);
        step();
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_count", 32'(count), 32'd3);

        // Immediate out of range: lw imm=2048, beq imm=3
        pulse_start();
        chk("start_clears_done", 32'(done), 32'd0);
        chk("start_clears_count", 32'(count), 32'd0);
        drive(2'b00, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd2048, 1'b0);
`ifdef ENC_RANGE_CHECK_EN
        expect_w(2'd0, 32'h0000_0013, 3'd1);
`else
        expect_w(2'd0, 32'h8001_2283, 3'd1);
`endif
        step();
        drive(2'b11, 3'd0, 1'b0, 5'd0, 5'd5, 5'd6, 13'd3, 1'b1);
`ifdef ENC_RANGE_CHECK_EN
        expect_w(2'd1, 32'h0000_0013, 3'd2);
`else
        expect_w(2'd1, 32'h0062_8163, 3'd2);
`endif
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
`ifdef ENC_RANGE_CHECK_EN
        chk("range_err", 32'(err_imm), 32'd1);
`else
        chk("range_err", 32'(err_imm), 32'd0);
`endif
        chk("range_done", 32'(done), 32'd1);

        // Fill all four words without in_last; fifth beat must be refused
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            drive(2'b10, 3'd0, 1'b0, 5'(i + 1), 5'd1, 5'd2, 13'd0, 1'b0);
            if (i < 4) expect_w(2'(i), 32'h0020_8033 | (32'(i + 1) << 7), 3'(i + 1));
            step();
        end
        chk("fill_ready", 32'(in_ready), 32'd0);
        step();
        in_valid = 1'b0;
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_done", 32'(done), 32'd1);

        // start in RUN with a valid beat: that beat is discarded
        pulse_start();
        start = 1'b1;
        drive(2'b00, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8, 1'b0);
        step();
        start = 1'b0;
        chk("restart_no_strobe", 32'(imem_we), 32'd0);
        drive(2'b01, 3'd0, 1'b0, 5'd0, 5'd3, 5'd6, 13'd12, 1'b0);
        expect_w(2'd0, 32'h0061_A623, 3'd1);
        step();

        // Reset in the middle of a burst drops the pending strobe
        drive(2'b10, 3'd0, 1'b1, 5'd7, 5'd5, 5'd6, 13'd0, 1'b0);
        expect_w(2'd1, 32'h4062_83B3, 3'd2);
        step();
        drive(2'b11, 3'd0, 1'b0, 5'd0, 5'd5, 5'd6, 13'h1FFC, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_we", 32'(imem_we), 32'd0);
        step();
        in_valid = 1'b0;
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_err", 32'(err_imm), 32'd0);
        #3;
        rst_n = 1'b1;
        step();
        pulse_start();
        drive(2'b00, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 13'd8, 1'b1);
        expect_w(2'd0, 32'h0081_2283, 3'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        chk("postrst_done", 32'(done), 32'd1);
        step();
        step();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
